// File: rtl/slc3_control_fsm.sv
// SLC-3 instruction-sequencing control unit.
// A Moore FSM that walks fetch, decode and execute. It drives every datapath
// load enable, bus gate and mux select, plus the active-low SRAM strobes.
// Each SRAM access holds its strobes for MEM_WAIT cycles.
module slc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2  // SRAM cycles per access, 1..7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        continue_i,
    input  logic [15:0] IR,
    input  logic        BEN,

    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,

    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,

    output logic [1:0]  PCMUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        MIO_EN,

    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE,

    output logic [4:0]  state_dbg
);

    typedef enum logic [4:0] {
        StHalted = 5'd0,
        StFetch1,
        StFetch2,
        StFetch3,
        StDecode,
        StAdd,
        StAnd,
        StNot,
        StBrEval,
        StBrTake,
        StJmp,
        StJsr1,
        StJsr2,
        StLdr1,
        StLdr2,
        StLdr3,
        StStr1,
        StStr2,
        StStr3,
        StPause1,
        StPause2
    } state_e;

    localparam logic [3:0] OpBr    = 4'b0000;
    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpJsr   = 4'b0100;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpLdr   = 4'b0110;
    localparam logic [3:0] OpStr   = 4'b0111;
    localparam logic [3:0] OpNot   = 4'b1001;
    localparam logic [3:0] OpJmp   = 4'b1100;
    localparam logic [3:0] OpPause = 4'b1101;

    // Count value on the final cycle of a memory access.
    localparam logic [2:0] WaitLast = 3'(MEM_WAIT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       wait_done;

    // Only the opcode, IR[11] (JSR mode) and IR[5] (immediate select) steer control.
    logic unused_ir;
    assign unused_ir = ^{IR[10:6], IR[4:0]};

    assign wait_done = (cnt_q == WaitLast);
    assign state_dbg = state_q;

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StHalted;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The counter runs only inside wait states and clears on exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            StHalted: begin
                if (run) begin
                    state_d = StFetch1;
                end
            end
            StFetch1: state_d = StFetch2;
            StFetch2: begin
                if (wait_done) begin
                    state_d = StFetch3;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StFetch3: state_d = StDecode;
            StDecode: begin
                case (IR[15:12])
                    OpAdd:   state_d = StAdd;
                    OpAnd:   state_d = StAnd;
                    OpNot:   state_d = StNot;
                    OpBr:    state_d = StBrEval;
                    OpJmp:   state_d = StJmp;
                    OpJsr:   state_d = StJsr1;
                    OpLdr:   state_d = StLdr1;
                    OpStr:   state_d = StStr1;
                    OpPause: state_d = StPause1;
                    default: state_d = StFetch1;  // unsupported opcode acts as NOP
                endcase
            end
            StAdd, StAnd, StNot: state_d = StFetch1;
            StBrEval: state_d = BEN ? StBrTake : StFetch1;
            StBrTake: state_d = StFetch1;
            StJmp:    state_d = StFetch1;
            StJsr1:   state_d = StJsr2;
            StJsr2:   state_d = StFetch1;
            StLdr1:   state_d = StLdr2;
            StLdr2: begin
                if (wait_done) begin
                    state_d = StLdr3;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StLdr3:   state_d = StFetch1;
            StStr1:   state_d = StStr2;
            StStr2:   state_d = StStr3;
            StStr3: begin
                if (wait_done) begin
                    state_d = StFetch1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StPause1: begin
                if (continue_i) begin
                    state_d = StPause2;
                end
            end
            StPause2: begin
                // Wait for release so a held continue_i cannot skip the next PAUSE.
                if (!continue_i) begin
                    state_d = StFetch1;
                end
            end
            default:  state_d = StHalted;
        endcase
    end

    // Moore output decode; only SR2MUX and the JSR2 address select also look at IR.
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        MIO_EN     = 1'b0;
        Mem_CE     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (state_q)
            StFetch1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = 2'b00;
                LD_PC  = 1'b1;
            end
            StFetch2, StLdr2: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = wait_done;
            end
            StFetch3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            StDecode: LD_BEN = 1'b1;
            StAdd, StAnd, StNot: begin
                SR1MUX  = 1'b1;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                DRMUX   = 1'b0;
                if (state_q == StAdd) begin
                    ALUK   = 2'b00;
                    SR2MUX = IR[5];
                end else if (state_q == StAnd) begin
                    ALUK   = 2'b01;
                    SR2MUX = IR[5];
                end else begin
                    ALUK   = 2'b10;
                end
            end
            StBrTake: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            StJmp: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b00;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            StJsr1: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            StJsr2: begin
                PCMUX = 2'b10;
                LD_PC = 1'b1;
                if (IR[11]) begin
                    ADDR1MUX = 1'b0;
                    ADDR2MUX = 2'b11;
                end else begin
                    SR1MUX   = 1'b1;
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = 2'b00;
                end
            end
            StLdr1, StStr1: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            StLdr3: begin
                GateMDR = 1'b1;
                DRMUX   = 1'b0;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StStr2: begin
                SR1MUX  = 1'b0;
                ALUK    = 2'b11;
                GateALU = 1'b1;
                MIO_EN  = 1'b0;
                LD_MDR  = 1'b1;
            end
            StStr3: begin
                Mem_CE = 1'b0;
                Mem_WE = 1'b0;
            end
            StPause1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Self-checking bench for slc3_control_fsm.
// Two instances (MEM_WAIT = 2 and 3) are exercised one after the other.
// For each instruction a reference model lists the expected control word of
// every cycle from the instruction rules. The bench checks each word and some
// global strobe/bus invariants.
module tb_slc3_control_fsm;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       drmux, sr1mux, sr2mux, mio_en, mem_ce, mem_oe, mem_we;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_s  [2];
    logic        run_s  [2];
    logic        cont_s [2];
    logic [15:0] ir_s   [2];
    logic        ben_s  [2];
    ctl_t        obs    [2];

    int   tests = 0;
    int   fails = 0;
    ctl_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic       addr1mux, drmux, sr1mux, sr2mux, mio_en, mem_ce, mem_oe, mem_we;
        logic [4:0] unused_state_dbg;

        slc3_control_fsm #(.MEM_WAIT((g == 0) ? 2 : 3)) u_dut (
            .clk        (clk),
            .reset      (rst_s[g]),
            .run        (run_s[g]),
            .continue_i (cont_s[g]),
            .IR         (ir_s[g]),
            .BEN        (ben_s[g]),
            .LD_MAR     (ld_mar),
            .LD_MDR     (ld_mdr),
            .LD_IR      (ld_ir),
            .LD_BEN     (ld_ben),
            .LD_CC      (ld_cc),
            .LD_REG     (ld_reg),
            .LD_PC      (ld_pc),
            .LD_LED     (ld_led),
            .GatePC     (gate_pc),
            .GateMDR    (gate_mdr),
            .GateALU    (gate_alu),
            .GateMARMUX (gate_marmux),
            .PCMUX      (pcmux),
            .ADDR1MUX   (addr1mux),
            .ADDR2MUX   (addr2mux),
            .ALUK       (aluk),
            .DRMUX      (drmux),
            .SR1MUX     (sr1mux),
            .SR2MUX     (sr2mux),
            .MIO_EN     (mio_en),
            .Mem_CE     (mem_ce),
            .Mem_OE     (mem_oe),
            .Mem_WE     (mem_we),
            .state_dbg  (unused_state_dbg)
        );

        assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                         gate_pc, gate_mdr, gate_alu, gate_marmux,
                         pcmux, addr1mux, addr2mux, aluk,
                         drmux, sr1mux, sr2mux, mio_en, mem_ce, mem_oe, mem_we};
    end

    function automatic int mw(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.mem_ce = 1'b1;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input int k, input ctl_t e, input string tag);
        ctl_t o;
        o = obs[k];
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
        tests++;
        assert ($countones({o.gate_pc, o.gate_mdr, o.gate_alu, o.gate_marmux}) <= 1) else begin
            fails++;
            $error("FAIL %s-bus observed gates=%b expected at most one high", tag,
                   {o.gate_pc, o.gate_mdr, o.gate_alu, o.gate_marmux});
        end
        tests++;
        assert (o.mem_oe || o.mem_we) else begin
            fails++;
            $error("FAIL %s-oewe observed OE=%b WE=%b expected not both low", tag,
                   o.mem_oe, o.mem_we);
        end
        tests++;
        assert (o.mem_we || !(o.ld_mar || o.ld_mdr)) else begin
            fails++;
            $error("FAIL %s-weld observed WE=%b LD_MAR=%b LD_MDR=%b expected no load", tag,
                   o.mem_we, o.ld_mar, o.ld_mdr);
        end
    endtask

    // Reference model: memory access of w cycles (read or write).
    task automatic push_mem(input int w, input bit is_read);
        ctl_t c;
        for (int i = 0; i < w; i++) begin
            c = idle();
            c.mem_ce = 1'b0;
            if (is_read) begin
                c.mem_oe = 1'b0;
                c.mio_en = 1'b1;
                c.ld_mdr = (i == w - 1);
            end else begin
                c.mem_we = 1'b0;
            end
            exp_q.push_back(c);
        end
    endtask

    // Reference model: FETCH1, memory read, IR load, decode.
    task automatic push_fetch(input int w);
        ctl_t c;
        c = idle();
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
        exp_q.push_back(c);
        push_mem(w, 1'b1);
        c = idle();
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
        exp_q.push_back(c);
        c = idle();
        c.ld_ben = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic push_addr();
        ctl_t c;
        c = idle();
        c.sr1mux      = 1'b1;
        c.addr1mux    = 1'b1;
        c.addr2mux    = 2'b01;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
        exp_q.push_back(c);
    endtask

    // Reference model: execute phase of one (non-PAUSE) instruction.
    task automatic push_exec(input int w, input logic [15:0] ir, input logic ben);
        ctl_t c;
        logic [3:0] op;
        op = ir[15:12];
        c = idle();
        case (op)
            4'h1, 4'h5, 4'h9: begin
                c.sr1mux   = 1'b1;
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                c.aluk     = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
                c.sr2mux   = (op != 4'h9) && ir[5];
                exp_q.push_back(c);
            end
            4'h0: begin
                exp_q.push_back(c);
                if (ben) begin
                    c.addr2mux = 2'b10;
                    c.pcmux    = 2'b10;
                    c.ld_pc    = 1'b1;
                    exp_q.push_back(c);
                end
            end
            4'hC: begin
                c.sr1mux   = 1'b1;
                c.addr1mux = 1'b1;
                c.pcmux    = 2'b10;
                c.ld_pc    = 1'b1;
                exp_q.push_back(c);
            end
            4'h4: begin
                c.gate_pc = 1'b1;
                c.drmux   = 1'b1;
                c.ld_reg  = 1'b1;
                exp_q.push_back(c);
                c = idle();
                c.pcmux = 2'b10;
                c.ld_pc = 1'b1;
                if (ir[11]) begin
                    c.addr2mux = 2'b11;
                end else begin
                    c.sr1mux   = 1'b1;
                    c.addr1mux = 1'b1;
                end
                exp_q.push_back(c);
            end
            4'h6: begin
                push_addr();
                push_mem(w, 1'b1);
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                exp_q.push_back(c);
            end
            4'h7: begin
                push_addr();
                c.aluk     = 2'b11;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
                exp_q.push_back(c);
                push_mem(w, 1'b0);
            end
            default: ;
        endcase
    endtask

    // Compare every queued cycle, one per clock, sampled at the falling edge.
    task automatic play(input int k, input string tag);
        int i = 0;
        while (exp_q.size() > 0) begin
            ctl_t e = exp_q.pop_front();
            @(negedge clk);
            check_cycle(k, e, $sformatf("%s k%0d c%0d", tag, k, i));
            step();
            i++;
        end
    endtask

    // Called during FETCH1; returns during the next instruction's FETCH1.
    task automatic run_instr(input int k, input logic [15:0] ir, input logic ben,
                             input string tag);
        ir_s[k]  = ir;
        ben_s[k] = ben;
        push_fetch(mw(k));
        push_exec(mw(k), ir, ben);
        play(k, tag);
    endtask

    task automatic run_pause(input int k, input logic cont0, input int n_wait,
                             input int n_hold, input string tag);
        ctl_t led;
        led = idle();
        led.ld_led = 1'b1;
        ir_s[k]   = 16'hD000;
        cont_s[k] = cont0;
        push_fetch(mw(k));
        play(k, tag);
        if (!cont0) begin
            for (int i = 0; i < n_wait; i++) begin
                @(negedge clk);
                check_cycle(k, led, $sformatf("%s wait%0d", tag, i));
                step();
            end
            cont_s[k] = 1'b1;
        end
        @(negedge clk);
        check_cycle(k, led, {tag, " p1last"});
        step();
        for (int i = 0; i < n_hold; i++) begin
            @(negedge clk);
            check_cycle(k, idle(), $sformatf("%s hold%0d", tag, i));
            step();
        end
        cont_s[k] = 1'b0;
        @(negedge clk);
        check_cycle(k, idle(), {tag, " p2last"});
        step();
    endtask

    task automatic run_random(input int k, input int n);
        logic [3:0]  op;
        logic [15:0] ir;
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hD) op = 4'h1;
            ir = {op, 12'($urandom)};
            run_instr(k, ir, 1'($urandom), $sformatf("rnd%0d op%h", i, op));
        end
    endtask

    task automatic start(input int k);
        run_s[k] = 1'b1;
        @(negedge clk);
        check_cycle(k, idle(), "halt-run");
        step();
    endtask

    initial begin
        ctl_t c;
        for (int k = 0; k < 2; k++) begin
            rst_s[k]  = 1'b1;
            run_s[k]  = 1'b0;
            cont_s[k] = 1'b0;
            ir_s[k]   = 16'h0000;
            ben_s[k]  = 1'b0;
        end
        step();
        step();
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_cycle(0, idle(), $sformatf("reset-idle k0 c%0d", i));
            check_cycle(1, idle(), $sformatf("reset-idle k1 c%0d", i));
            step();
        end

        // MEM_WAIT = 2 instance.
        start(0);
        run_instr(0, 16'h1261, 1'b0, "add");
        run_s[0] = 1'b0;  // ignored once running
        run_instr(0, 16'h0A05, 1'b0, "br-nt");
        run_instr(0, 16'h0A05, 1'b1, "br-t");
        run_instr(0, 16'h4800, 1'b0, "jsr");
        run_instr(0, 16'h4080, 1'b0, "jsrr");
        run_random(0, 30);
        run_pause(0, 1'b0, 5, 4, "pause");
        run_pause(0, 1'b1, 0, 4, "pause-hi");
        run_instr(0, 16'h5020, 1'b0, "and");

        // LDR interrupted by reset during its second memory cycle.
        ir_s[0] = 16'h6283;
        push_fetch(2);
        push_addr();
        c = idle();
        c.mem_ce = 1'b0;
        c.mem_oe = 1'b0;
        c.mio_en = 1'b1;
        exp_q.push_back(c);
        play(0, "ldr");
        rst_s[0] = 1'b1;
        c.ld_mdr = 1'b1;
        @(negedge clk);
        check_cycle(0, c, "ldr2-last");
        step();
        rst_s[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_cycle(0, idle(), $sformatf("ldr-reset c%0d", i));
            step();
        end

        // MEM_WAIT = 3 instance.
        start(1);
        run_instr(1, 16'h7442, 1'b0, "str");
        run_s[1] = 1'b0;
        run_instr(1, 16'h6283, 1'b0, "ldr3");
        run_random(1, 20);
        run_instr(1, 16'h1261, 1'b0, "add3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
